instruction_fetch_unit: RTL and testbench

Fetch stage of the multi-cycle core, directly upstream of `instruction_decoder_unit`. Owns the program counter. On request from the control unit it issues a single-word read to instruction memory and waits out a variable-latency ready handshake. It then captures the 16-bit word and pulses `inst_en` so the decoder latches `inst_data`. It also accepts PC loads from branch/PC write-back, flushing any fetch in flight, and flags misaligned or timed-out fetches.

---
 rtl/instruction_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues single-word instruction reads with a
// variable-latency ready handshake, and strobes captured words to the decoder.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [15:0] pc_in,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] inst_data,
    output logic        inst_en,
    output logic [15:0] pc_out,
    output logic        busy,
    output logic        fetch_fault
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    // Last not-ready cycle index before the request is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] inst_q, inst_d;
    logic        rd_q, rd_d;
    logic        en_q, en_d;
    logic        fault_q, fault_d;
    logic        flush_q, flush_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] target;

    assign target = pc_load ? pc_in : pc_q;

    // NOTE: every *_d gets a hold/default value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        rd_d    = rd_q;
        en_d    = 1'b0;
        fault_d = fault_q;
        flush_d = flush_q;
        wait_d  = wait_q;

        // A PC load always takes effect; fault-raising events below override the clear.
        if (pc_load) begin
            pc_d    = pc_in;
            fault_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fetch_start) begin
                    if (target[0]) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        rd_d    = 1'b1;
                        addr_d  = target;
                        wait_d  = 8'd0;
                        flush_d = 1'b0;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    flush_d = 1'b0;
                    // A load now or earlier in this request discards the returned word.
                    if (!(flush_q || pc_load)) begin
                        inst_d = mem_rdata;
                        pc_d   = 16'(addr_q + 16'd2);
                        en_d   = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    flush_d = 1'b0;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (pc_load) flush_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            inst_q  <= 16'h0000;
            rd_q    <= 1'b0;
            en_q    <= 1'b0;
            fault_q <= 1'b0;
            flush_q <= 1'b0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            rd_q    <= rd_d;
            en_q    <= en_d;
            fault_q <= fault_d;
            flush_q <= flush_d;
            wait_q  <= wait_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_rd      = rd_q;
    assign inst_data   = inst_q;
    assign inst_en     = en_q;
    assign pc_out      = pc_q;
    assign busy        = (state_q == REQ);
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// fetch transactions, each checked against a transaction-level PC/fault model.
module tb_instruction_fetch_unit;

    localparam int WAIT_LIMIT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_start = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] inst_data;
    logic        inst_en;
    logic [15:0] pc_out;
    logic        busy;
    logic        fetch_fault;

    int checks = 0;
    int failures = 0;

    // Model of architecturally visible state
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_inst = 16'h0000;
    logic        m_fault = 1'b0;

    instruction_fetch_unit #(
        .RESET_PC  (16'h0000),
        .WAIT_LIMIT(WAIT_LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_start(fetch_start),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .inst_data  (inst_data),
        .inst_en    (inst_en),
        .pc_out     (pc_out),
        .busy       (busy),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge: loads the PC alone while idle.
    task automatic load_only(input logic [15:0] v);
        pc_load = 1'b1;
        pc_in   = v;
        @(negedge clk);
        pc_load = 1'b0;
        m_pc    = v;
        m_fault = 1'b0;
        check("load_pc", pc_out, m_pc);
        check("load_fault", {15'd0, fetch_fault}, {15'd0, m_fault});
    endtask

    // Called just after a negedge: one fetch whose memory answers after `lat`
    // not-ready cycles; optional PC load during request cycle `flush_at`.
    task automatic run_fetch(input logic load, input logic [15:0] load_val, input int lat,
                             input int flush_at, input logic [15:0] flush_val,
                             input logic [15:0] rdata);
        logic [15:0] target;
        logic        flushed;
        logic        done;
        logic        exp_en;
        int          rd_cycles;
        fetch_start = 1'b1;
        pc_load     = load;
        pc_in       = load_val;
        target      = load ? load_val : m_pc;
        if (load) begin
            m_pc    = load_val;
            m_fault = 1'b0;
        end
        @(negedge clk);
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        check("inst_en_one_cycle", {15'd0, inst_en}, 16'd0);
        if (target[0]) begin
            m_fault = 1'b1;
            check("odd_no_rd", {15'd0, mem_rd}, 16'd0);
            check("odd_no_busy", {15'd0, busy}, 16'd0);
            check("odd_fault", {15'd0, fetch_fault}, 16'd1);
            check("odd_pc", pc_out, m_pc);
            return;
        end
        flushed   = 1'b0;
        done      = 1'b0;
        exp_en    = 1'b0;
        rd_cycles = 0;
        for (int c = 0; c < WAIT_LIMIT && !done; c++) begin
            check("req_rd", {15'd0, mem_rd}, 16'd1);
            check("req_busy", {15'd0, busy}, 16'd1);
            check("req_addr", mem_addr, target);
            check("req_pc", pc_out, m_pc);
            check("req_fault", {15'd0, fetch_fault}, {15'd0, m_fault});
            check("req_no_en", {15'd0, inst_en}, 16'd0);
            rd_cycles++;
            mem_ready = (c == lat);
            mem_rdata = (c == lat) ? rdata : 16'($urandom);
            pc_load   = (c == flush_at);
            pc_in     = flush_val;
            @(negedge clk);
            mem_ready = 1'b0;
            pc_load   = 1'b0;
            if (c == flush_at) begin
                m_pc    = flush_val;
                m_fault = 1'b0;
                flushed = 1'b1;
            end
            if (c == lat) begin
                done = 1'b1;
                if (!flushed) begin
                    m_inst = rdata;
                    m_pc   = target + 16'd2;
                    exp_en = 1'b1;
                end
            end else if (c == WAIT_LIMIT - 1) begin
                done    = 1'b1;
                m_fault = 1'b1;
            end
        end
        check("rd_cycles", 16'(rd_cycles), 16'((lat < WAIT_LIMIT) ? lat + 1 : WAIT_LIMIT));
        check("end_rd", {15'd0, mem_rd}, 16'd0);
        check("end_busy", {15'd0, busy}, 16'd0);
        check("end_inst_en", {15'd0, inst_en}, {15'd0, exp_en});
        check("end_inst_data", inst_data, m_inst);
        check("end_pc", pc_out, m_pc);
        check("end_fault", {15'd0, fetch_fault}, {15'd0, m_fault});
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] fv;
        int          lat;
        int          fat;

        // Reset state
        #3;
        check("rst_rd", {15'd0, mem_rd}, 16'd0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_inst", inst_data, 16'h0000);
        check("rst_en", {15'd0, inst_en}, 16'd0);
        check("rst_pc", pc_out, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_fault", {15'd0, fetch_fault}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Zero-wait fetch from reset PC
        run_fetch(1'b0, 16'h0000, 0, -1, 16'h0000, 16'h4C81);
        check("t1_data", inst_data, 16'h4C81);
        check("t1_pc", pc_out, 16'h0002);

        // Three wait states at 0x0010
        @(negedge clk);
        load_only(16'h0010);
        run_fetch(1'b0, 16'h0000, 3, -1, 16'h0000, 16'h6A55);
        check("t2_pc", pc_out, 16'h0012);

        // Flush mid-request, then fetch from the loaded address
        @(negedge clk);
        load_only(16'h0004);
        run_fetch(1'b0, 16'h0000, 3, 1, 16'h0200, 16'h1111);
        check("t3_inst_kept", inst_data, 16'h6A55);
        check("t3_pc", pc_out, 16'h0200);
        run_fetch(1'b0, 16'h0000, 0, -1, 16'h0000, 16'h2222);

        // Load coincident with mem_ready also flushes
        run_fetch(1'b0, 16'h0000, 2, 2, 16'h0300, 16'h3333);
        check("t3b_pc", pc_out, 16'h0300);

        // Misaligned target, then recovery
        @(negedge clk);
        load_only(16'h0101);
        run_fetch(1'b0, 16'h0000, 0, -1, 16'h0000, 16'h0000);
        run_fetch(1'b0, 16'h0000, 0, -1, 16'h0000, 16'h0000);
        @(negedge clk);
        load_only(16'h0100);
        run_fetch(1'b0, 16'h0000, 1, -1, 16'h0000, 16'h5A5A);

        // Ready in the final allowed cycle completes; one cycle later times out
        run_fetch(1'b0, 16'h0000, WAIT_LIMIT - 1, -1, 16'h0000, 16'h7E7E);
        run_fetch(1'b0, 16'h0000, 1000, -1, 16'h0000, 16'h0000);
        check("t5_fault", {15'd0, fetch_fault}, 16'd1);

        // Reset asserted mid-request (fault and inst_data are non-default here)
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        check("t7_in_req", {15'd0, mem_rd}, 16'd1);
        #2 reset = 1'b0;
        #1;
        check("t7_rd", {15'd0, mem_rd}, 16'd0);
        check("t7_busy", {15'd0, busy}, 16'd0);
        check("t7_inst", inst_data, 16'h0000);
        check("t7_pc", pc_out, 16'h0000);
        check("t7_addr", mem_addr, 16'h0000);
        check("t7_fault", {15'd0, fetch_fault}, 16'd0);
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ready = 1'b0;
        check("t7_ignored_en", {15'd0, inst_en}, 16'd0);
        check("t7_ignored_data", inst_data, 16'h0000);
        m_pc    = 16'h0000;
        m_inst  = 16'h0000;
        m_fault = 1'b0;

        // PC wrap
        run_fetch(1'b1, 16'hFFFE, 1, -1, 16'h0000, 16'hBEEF);
        check("t6_wrap", pc_out, 16'h0000);

        // Random transactions
        for (int i = 0; i < 150; i++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 7) != 0) v[0] = 1'b0;
            fv = 16'($urandom);
            if ($urandom_range(0, 7) != 0) fv[0] = 1'b0;
            lat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(WAIT_LIMIT, 20))
                                              : int'($urandom_range(0, WAIT_LIMIT - 1));
            fat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, WAIT_LIMIT - 1)) : -1;
            run_fetch($urandom_range(0, 2) == 0, v, lat, fat, fv, 16'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                v = 16'($urandom);
                v[0] = 1'b0;
                load_only(v);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
